// File: rtl/matmul_tile_ctrl_pkg.sv
// Shared types and sizing helpers for the matmul tile sequencer.
package matmul_tile_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StLoadA,
    StFire,
    StKick,
    StWait,
    StFin
  } state_e;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tile_words(input int unsigned row_pe,
                                             input int unsigned col_pe);
    return row_pe * col_pe;
  endfunction

  function automatic int unsigned addr_w(input int unsigned row1, input int unsigned col1,
                                         input int unsigned col2, input int unsigned tw);
    int unsigned a_words;
    int unsigned b_words;
    a_words = row1 * col1;
    b_words = col1 * col2;
    return idx_w(((a_words > b_words) ? a_words : b_words) * tw);
  endfunction

endpackage

// File: rtl/matmul_tile_ctrl_tile_addr_gen.sv
// Three-level nested tile counter (outer, middle, word) with terminal flag and linear address.
module matmul_tile_ctrl_tile_addr_gen
  import matmul_tile_ctrl_pkg::*;
#(
  parameter int unsigned OuterN = 2,
  parameter int unsigned MidN   = 2,
  parameter int unsigned Tw     = 4,
  parameter int unsigned Aw     = 4,
  localparam int unsigned Ow    = idx_w(OuterN),
  localparam int unsigned Mw    = idx_w(MidN),
  localparam int unsigned Ww    = idx_w(Tw)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [Ow-1:0] outer,
  output logic [Mw-1:0] mid,
  output logic [Ww-1:0] w_idx,
  output logic [Aw-1:0] addr,
  output logic          last
);

  logic [Ow-1:0] outer_q;
  logic [Mw-1:0] mid_q;
  logic [Ww-1:0] w_q;
  logic          w_max;
  logic          mid_max;
  logic          outer_max;

  always_comb begin
    w_max     = (w_q == Ww'(Tw - 1));
    mid_max   = (mid_q == Mw'(MidN - 1));
    outer_max = (outer_q == Ow'(OuterN - 1));
    last      = w_max && mid_max && outer_max;
    addr      = Aw'((32'(outer_q) * MidN + 32'(mid_q)) * Tw + 32'(w_q));
    outer     = outer_q;
    mid       = mid_q;
    w_idx     = w_q;
  end

  // Counters park on the terminal count so the address holds after the phase ends.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      outer_q <= '0;
      mid_q   <= '0;
      w_q     <= '0;
    end else if (en && !last) begin
      if (w_max) begin
        w_q <= '0;
        if (mid_max) begin
          mid_q   <= '0;
          outer_q <= outer_q + 1'b1;
        end else begin
          mid_q <= mid_q + 1'b1;
        end
      end else begin
        w_q <= w_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_tile_ctrl.sv
// Sequencer that streams B then A tiles into the PE array, kicks it and waits for completion.
module matmul_tile_ctrl
  import matmul_tile_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROW1   = 64,
  parameter int unsigned COL1   = 64,
  parameter int unsigned COL2   = 64,
  parameter int unsigned ROW_PE = 4,
  parameter int unsigned COL_PE = 4,
  localparam int unsigned TW    = tile_words(ROW_PE, COL_PE),
  localparam int unsigned AW    = addr_w(ROW1, COL1, COL2, TW),
  localparam int unsigned IW    = idx_w(ROW1),
  localparam int unsigned JW    = idx_w(COL2),
  localparam int unsigned KW    = idx_w(COL1),
  localparam int unsigned WW    = idx_w(TW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  output logic [AW-1:0] MemAdd_a,
  output logic [AW-1:0] MemAdd_b,
  output logic          memw_a,
  output logic          memw_b,
  output logic [IW-1:0] sel_i,
  output logic [JW-1:0] sel_j,
  output logic [KW-1:0] sel_k,
  output logic [WW-1:0] word_idx,
  output logic          a_we,
  output logic          b_we,
  output logic          mm_start,
  input  logic          mm_done,
  output logic          busy,
  output logic          done
);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end

  state_e state_q;

  logic          b_clr, b_en, b_last;
  logic          a_clr, a_en, a_last;
  logic [KW-1:0] b_k;
  logic [JW-1:0] b_j;
  logic [WW-1:0] b_w;
  logic [IW-1:0] a_i;
  logic [KW-1:0] a_k;
  logic [WW-1:0] a_w;

  always_comb begin
    b_clr = (state_q == StIdle) && Start;
    b_en  = (state_q == StLoadB);
    a_clr = (state_q == StLoadB) && b_last;
    a_en  = (state_q == StLoadA);
  end

  // B order: k outer, j middle, word inner.
  matmul_tile_ctrl_tile_addr_gen #(
    .OuterN (COL1),
    .MidN   (COL2),
    .Tw     (TW),
    .Aw     (AW)
  ) u_gen_b (
    .clk    (clk),
    .rst    (rst),
    .clr    (b_clr),
    .en     (b_en),
    .outer  (b_k),
    .mid    (b_j),
    .w_idx  (b_w),
    .addr   (MemAdd_b),
    .last   (b_last)
  );

  // A order: i outer, k middle, word inner.
  matmul_tile_ctrl_tile_addr_gen #(
    .OuterN (ROW1),
    .MidN   (COL1),
    .Tw     (TW),
    .Aw     (AW)
  ) u_gen_a (
    .clk    (clk),
    .rst    (rst),
    .clr    (a_clr),
    .en     (a_en),
    .outer  (a_i),
    .mid    (a_k),
    .w_idx  (a_w),
    .addr   (MemAdd_a),
    .last   (a_last)
  );

  assign memw_a = 1'b0;
  assign memw_b = 1'b0;

  // Strobes and indices are the address-cycle values delayed by one to match read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_i    <= '0;
      sel_j    <= '0;
      sel_k    <= '0;
      word_idx <= '0;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      mm_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start) begin
            state_q <= StLoadB;
            busy    <= 1'b1;
          end
        end
        StLoadB: begin
          b_we     <= 1'b1;
          sel_k    <= b_k;
          sel_j    <= b_j;
          word_idx <= b_w;
          if (b_last) state_q <= StLoadA;
        end
        StLoadA: begin
          a_we     <= 1'b1;
          sel_i    <= a_i;
          sel_k    <= a_k;
          word_idx <= a_w;
          if (a_last) state_q <= StFire;
        end
        StFire: begin
          mm_start <= 1'b1;
          state_q  <= StKick;
        end
        StKick: begin
          state_q <= StWait;
        end
        StWait: begin
          if (mm_done) begin
            done    <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Scoreboard bench for matmul_tile_ctrl on a 2x2x2 tile grid with 2x2 tiles.
module tb_matmul_tile_ctrl;
  import matmul_tile_ctrl_pkg::*;

  localparam int unsigned ROW1 = 2;
  localparam int unsigned COL1 = 2;
  localparam int unsigned COL2 = 2;
  localparam int unsigned RPE  = 2;
  localparam int unsigned CPE  = 2;
  localparam int TW = 4;
  localparam int LB = 16;
  localparam int LA = 16;
  localparam int unsigned AW = addr_w(ROW1, COL1, COL2, RPE * CPE);

  typedef struct {
    int cyc;
    int f0;
    int f1;
    int f2;
    int addr;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [AW-1:0] MemAdd_a, MemAdd_b;
  logic          memw_a, memw_b;
  logic [0:0]    sel_i, sel_j, sel_k;
  logic [1:0]    word_idx;
  logic          a_we, b_we, mm_start, mm_done, busy, done;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_raise = 1 << 30;
  int   prev_mem_a = 0;
  int   prev_mem_b = 0;
  bit   expect_idle = 1'b0;
  rec_t exp_b[$];
  rec_t exp_a[$];
  int   exp_kick[$];
  int   exp_done[$];

  matmul_tile_ctrl #(
    .WIDTH    (32),
    .ROW1     (ROW1),
    .COL1     (COL1),
    .COL2     (COL2),
    .ROW_PE   (RPE),
    .COL_PE   (CPE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .MemAdd_a (MemAdd_a),
    .MemAdd_b (MemAdd_b),
    .memw_a   (memw_a),
    .memw_b   (memw_b),
    .sel_i    (sel_i),
    .sel_j    (sel_j),
    .sel_k    (sel_k),
    .word_idx (word_idx),
    .a_we     (a_we),
    .b_we     (b_we),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mm_done = (cyc >= done_raise);
  endtask

  task automatic flush();
    exp_b.delete();
    exp_a.delete();
    exp_kick.delete();
    exp_done.delete();
  endtask

  // Drive one accepted Start in the current cycle and queue everything it should produce.
  task automatic start_op(input int raise_rel, output int s);
    rec_t r;
    int   k, j, i, w, wait_start;
    s          = cyc;
    done_raise = s + raise_rel;
    mm_done    = (cyc >= done_raise);
    Start      = 1'b1;
    for (int n = 0; n < LB; n++) begin
      k = n / (COL2 * TW);
      j = (n / TW) % COL2;
      w = n % TW;
      r = '{cyc: s + 2 + n, f0: k, f1: j, f2: w, addr: (k * COL2 + j) * TW + w};
      exp_b.push_back(r);
    end
    for (int n = 0; n < LA; n++) begin
      i = n / (COL1 * TW);
      k = (n / TW) % COL1;
      w = n % TW;
      r = '{cyc: s + 2 + LB + n, f0: i, f1: k, f2: w, addr: (i * COL1 + k) * TW + w};
      exp_a.push_back(r);
    end
    exp_kick.push_back(s + 2 + LB + LA);
    wait_start = s + 3 + LB + LA;
    exp_done.push_back(((done_raise > wait_start) ? done_raise : wait_start) + 1);
    tick();
    Start = 1'b0;
  endtask

  // Run until the queued done is seen, optionally pulsing Start at two offsets from s.
  task automatic wait_done(input int s, input int p1, input int p2, input int budget);
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < budget) begin
      Start = (cyc == s + p1) || (cyc == s + p2);
      tick();
      n++;
    end
    Start = 1'b0;
    if (exp_done.size() != 0) begin
      check_eq("done_timeout", exp_done.size(), 0);
      flush();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_a"}, int'(MemAdd_a), 0);
    check_eq({tag, "_mem_b"}, int'(MemAdd_b), 0);
    check_eq({tag, "_sel"}, int'({sel_i, sel_j, sel_k, word_idx}), 0);
    check_eq({tag, "_strobes"}, int'({a_we, b_we, mm_start, done, memw_a, memw_b}), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
  endtask

  always @(negedge clk) begin
    rec_t r;
    int   t;
    check_eq("memw", int'({memw_a, memw_b}), 0);
    check_eq("we_excl", int'(a_we & b_we), 0);
    if (expect_idle) begin
      check_eq("busy_after_done", int'(busy), 0);
      expect_idle = 1'b0;
    end
    if (b_we) begin
      if (exp_b.size() == 0) begin
        check_eq("b_we_spurious", int'(b_we), 0);
      end else begin
        r = exp_b.pop_front();
        check_eq("b_cyc", cyc, r.cyc);
        check_eq("b_sel_k", int'(sel_k), r.f0);
        check_eq("b_sel_j", int'(sel_j), r.f1);
        check_eq("b_word", int'(word_idx), r.f2);
        check_eq("b_addr", prev_mem_b, r.addr);
        check_eq("b_busy", int'(busy), 1);
      end
    end
    if (a_we) begin
      if (exp_a.size() == 0) begin
        check_eq("a_we_spurious", int'(a_we), 0);
      end else begin
        r = exp_a.pop_front();
        check_eq("a_cyc", cyc, r.cyc);
        check_eq("a_sel_i", int'(sel_i), r.f0);
        check_eq("a_sel_k", int'(sel_k), r.f1);
        check_eq("a_word", int'(word_idx), r.f2);
        check_eq("a_addr", prev_mem_a, r.addr);
      end
    end
    if (mm_start) begin
      if (exp_kick.size() == 0) begin
        check_eq("mm_start_spurious", int'(mm_start), 0);
      end else begin
        t = exp_kick.pop_front();
        check_eq("kick_cyc", cyc, t);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        check_eq("done_spurious", int'(done), 0);
      end else begin
        t = exp_done.pop_front();
        check_eq("done_cyc", cyc, t);
        check_eq("done_busy", int'(busy), 1);
        check_eq("hold_mem_a", int'(MemAdd_a), LA - 1);
        check_eq("hold_mem_b", int'(MemAdd_b), LB - 1);
        expect_idle = 1'b1;
      end
    end
    prev_mem_a = int'(MemAdd_a);
    prev_mem_b = int'(MemAdd_b);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst     = 1'b1;
    Start   = 1'b0;
    mm_done = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal run, then a back-to-back run issued the cycle after done.
    start_op(40, s);
    wait_done(s, -100, -100, 200);
    start_op(40, s);
    wait_done(s, -100, -100, 200);

    // Done already high before KICK: only WAIT may sample it.
    start_op(0, s);
    wait_done(s, -100, -100, 200);
    done_raise = 1 << 30;
    tick();

    // Extra Start pulses mid-run are ignored.
    start_op(40, s);
    wait_done(s, 5, 20, 200);
    repeat (4) tick();

    // Reset mid LOAD_B, then restart.
    start_op(40, s);
    while (cyc < s + 10) tick();
    rst = 1'b1;
    tick();
    flush();
    done_raise = 1 << 30;
    rst = 1'b0;
    check_all_zero("mid_reset");
    tick();
    start_op(40, s);
    wait_done(s, -100, -100, 200);
    repeat (4) tick();

    check_eq("left_b", exp_b.size(), 0);
    check_eq("left_a", exp_a.size(), 0);
    check_eq("left_kick", exp_kick.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
